// File: rtl/axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter
//
// Shares one downstream AXI-style read channel between three requesters:
// ICache line refill (i_*), DCache line refill (d_*) and uncached loads (u_*).
// One downstream read is outstanding at a time. A four-state FSM walks
// IDLE -> REQ -> RECV -> RESP -> IDLE:
//   IDLE : grant one requester, latch address/size/length and requester ID
//   REQ  : present m_rd_req until the downstream accepts it
//   RECV : collect beats into the line buffer (extra beats dropped)
//   RESP : one-cycle ret_valid pulse to the granted requester
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   i_rd_req/addr, i_rd_rdy          ICache refill request / accept
//   i_ret_valid, i_ret_data          ICache line return (LINE_W bits)
//   d_*                              same as i_* for the DCache
//   u_rd_req/addr/load_type, u_rd_rdy uncached request (load_type 0=byte,
//                                    1=half, 2=word)
//   u_ret_valid, u_ret_data          uncached word return (beat 0, raw)
//   m_rd_req/addr/len/size, m_rd_rdy downstream read request channel
//   m_ret_valid/last/data            downstream read data channel
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN  defined   : rotating priority, last granted is lowest
//                       undefined : fixed priority u > d > i, no pointer logic
// -----------------------------------------------------------------------------
module axi_read_arbiter #(
    parameter int LINE_WORD = 4,
    parameter int LINE_W    = LINE_WORD * 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_rd_req,
    input  logic [31:0]       i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic [LINE_W-1:0] i_ret_data,
    input  logic              d_rd_req,
    input  logic [31:0]       d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic [LINE_W-1:0] d_ret_data,
    input  logic              u_rd_req,
    input  logic [31:0]       u_rd_addr,
    input  logic [1:0]        u_load_type,
    output logic              u_rd_rdy,
    output logic              u_ret_valid,
    output logic [31:0]       u_ret_data,
    output logic              m_rd_req,
    output logic [31:0]       m_rd_addr,
    output logic [7:0]        m_rd_len,
    output logic [2:0]        m_rd_size,
    input  logic              m_rd_rdy,
    input  logic              m_ret_valid,
    input  logic              m_ret_last,
    input  logic [31:0]       m_ret_data
);

    localparam int IDX_W = $clog2(LINE_WORD);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = IDX_W + 2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] ID_I = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
    localparam logic [1:0] ID_U = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       word_q [LINE_WORD];
    logic [31:0]       word_d [LINE_WORD];
    logic [LINE_W-1:0] i_data_q, i_data_d;
    logic [LINE_W-1:0] d_data_q, d_data_d;
    logic [31:0]       u_data_q, u_data_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0]        last_q, last_d;
`endif

    logic              any_req;
    logic [1:0]        gnt_sel;
    logic [2:0]        u_size;
    logic              commit;
    logic [LINE_W-1:0] line_wr;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        i_data_d = i_data_q;
        d_data_d = d_data_q;
        u_data_d = u_data_q;
        commit   = 1'b0;
        line_wr  = '0;
        any_req  = u_rd_req | d_rd_req | i_rd_req;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
        // Search starts just after the last winner in the ring u -> d -> i -> u.
        case (last_q)
            ID_U:    gnt_sel = d_rd_req ? ID_D : (i_rd_req ? ID_I : ID_U);
            ID_D:    gnt_sel = i_rd_req ? ID_I : (u_rd_req ? ID_U : ID_D);
            default: gnt_sel = u_rd_req ? ID_U : (d_rd_req ? ID_D : ID_I);
        endcase
`else
        gnt_sel = u_rd_req ? ID_U : (d_rd_req ? ID_D : ID_I);
`endif

        case (u_load_type)
            2'd0:    u_size = 3'd0;
            2'd1:    u_size = 3'd1;
            default: u_size = 3'd2;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_REQ;
                    gnt_d   = gnt_sel;
                    cnt_d   = '0;
                    // Clearing the buffer makes words after an early last read as 0.
                    for (int k = 0; k < LINE_WORD; k++) word_d[k] = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = gnt_sel;
`endif
                    if (gnt_sel == ID_U) begin
                        addr_d = u_rd_addr;
                        len_d  = 8'd0;
                        size_d = u_size;
                    end else begin
                        addr_d = ((gnt_sel == ID_D) ? d_rd_addr : i_rd_addr) & ~OFF_MASK;
                        len_d  = 8'(LINE_WORD - 1);
                        size_d = 3'd2;
                    end
                end
            end
            ST_REQ: begin
                if (m_rd_rdy) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (m_ret_valid) begin
                    // Counter saturates at LINE_WORD so surplus beats are dropped.
                    if (cnt_q < CNT_FULL) begin
                        word_d[cnt_q[IDX_W-1:0]] = m_ret_data;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (m_ret_last) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Return registers load on the last beat so data is valid during RESP
        // and then hold until the next completion for the same requester.
        for (int k = 0; k < LINE_WORD; k++) line_wr[k*32 +: 32] = word_d[k];
        if (commit) begin
            case (gnt_q)
                ID_U:    u_data_d = line_wr[31:0];
                ID_D:    d_data_d = line_wr;
                default: i_data_d = line_wr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= ID_I;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            word_q   <= '{default: '0};
            i_data_q <= '0;
            d_data_q <= '0;
            u_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= ID_I;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            i_data_q <= i_data_d;
            d_data_q <= d_data_d;
            u_data_q <= u_data_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    // Ready is gated by resetn so it is 0 while reset is held and 1 on the
    // first cycle after release.
    assign i_rd_rdy    = resetn && (state_q == ST_IDLE);
    assign d_rd_rdy    = resetn && (state_q == ST_IDLE);
    assign u_rd_rdy    = resetn && (state_q == ST_IDLE);

    assign m_rd_req    = (state_q == ST_REQ);
    assign m_rd_addr   = addr_q;
    assign m_rd_len    = len_q;
    assign m_rd_size   = size_q;

    assign i_ret_valid = (state_q == ST_RESP) && (gnt_q == ID_I);
    assign d_ret_valid = (state_q == ST_RESP) && (gnt_q == ID_D);
    assign u_ret_valid = (state_q == ST_RESP) && (gnt_q == ID_U);
    assign i_ret_data  = i_data_q;
    assign d_ret_data  = d_data_q;
    assign u_ret_data  = u_data_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_read_arbiter
// Directed self-checking bench for axi_read_arbiter with LINE_WORD = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi_read_arbiter;

    localparam int LW = 4;
    localparam int LB = LW * 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          i_rd_req = 1'b0, d_rd_req = 1'b0, u_rd_req = 1'b0;
    logic [31:0]   i_rd_addr = '0, d_rd_addr = '0, u_rd_addr = '0;
    logic [1:0]    u_load_type = 2'd2;
    logic          i_rd_rdy, d_rd_rdy, u_rd_rdy;
    logic          i_ret_valid, d_ret_valid, u_ret_valid;
    logic [LB-1:0] i_ret_data, d_ret_data;
    logic [31:0]   u_ret_data;
    logic          m_rd_req;
    logic [31:0]   m_rd_addr;
    logic [7:0]    m_rd_len;
    logic [2:0]    m_rd_size;
    logic          m_rd_rdy = 1'b0, m_ret_valid = 1'b0, m_ret_last = 1'b0;
    logic [31:0]   m_ret_data = '0;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [LB-1:0] exp_line;

    axi_read_arbiter #(.LINE_WORD(LW)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
        .u_rd_req(u_rd_req), .u_rd_addr(u_rd_addr), .u_load_type(u_load_type),
        .u_rd_rdy(u_rd_rdy), .u_ret_valid(u_ret_valid), .u_ret_data(u_ret_data),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len),
        .m_rd_size(m_rd_size), .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid),
        .m_ret_last(m_ret_last), .m_ret_data(m_ret_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called on the falling edge while the FSM is in REQ. Handshakes, then
    // sends nbeats beats of value base*(k+1) with last on the final one.
    // Returns on the falling edge where the FSM sits in RESP.
    task automatic serve(input int nbeats, input logic [31:0] base);
        m_rd_rdy = 1'b1;
        @(negedge clk);
        m_rd_rdy = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            m_ret_valid = 1'b1;
            m_ret_data  = 32'(base * 32'(k + 1));
            m_ret_last  = (k == nbeats - 1);
            @(negedge clk);
        end
        m_ret_valid = 1'b0;
        m_ret_last  = 1'b0;
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (i_rd_rdy !== 1'b0 || d_rd_rdy !== 1'b0 || u_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b%b%b want 000", u_rd_rdy, d_rd_rdy, i_rd_rdy); end
        n_tests++; if (m_rd_req !== 1'b0 || m_rd_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mreq got %b/%h want 0/0", m_rd_req, m_rd_addr); end
        n_tests++; if (i_ret_data !== '0 || u_ret_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h/%h want 0", i_ret_data, u_ret_data); end
        resetn = 1'b1;
        #1;
        n_tests++; if (i_rd_rdy !== 1'b1 || u_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy got %b%b want 11", u_rd_rdy, i_rd_rdy); end
    endtask

    task automatic test_icache_refill();
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h1FC0_0014;
        @(negedge clk);
        i_rd_req = 1'b0;
        n_tests++; if (m_rd_req !== 1'b1 || m_rd_addr !== 32'h1FC0_0010) begin n_fail++; $display("FAIL icache_addr got %b/%h want 1/1fc00010", m_rd_req, m_rd_addr); end
        n_tests++; if (m_rd_len !== 8'd3 || m_rd_size !== 3'd2) begin n_fail++; $display("FAIL icache_len_size got %0d/%0d want 3/2", m_rd_len, m_rd_size); end
        n_tests++; if (i_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL icache_rdy_busy got %b want 0", i_rd_rdy); end
        serve(4, 32'h11);
        exp_line = {32'h44, 32'h33, 32'h22, 32'h11};
        n_tests++; if (i_ret_valid !== 1'b1 || d_ret_valid !== 1'b0 || u_ret_valid !== 1'b0) begin n_fail++; $display("FAIL icache_valid got %b%b%b want 001", u_ret_valid, d_ret_valid, i_ret_valid); end
        n_tests++; if (i_ret_data !== exp_line) begin n_fail++; $display("FAIL icache_data got %h want %h", i_ret_data, exp_line); end
        @(negedge clk);
        n_tests++; if (i_ret_valid !== 1'b0 || i_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL icache_pulse_end got %b/%b want 0/1", i_ret_valid, i_rd_rdy); end
        n_tests++; if (i_ret_data !== exp_line) begin n_fail++; $display("FAIL icache_hold got %h want %h", i_ret_data, exp_line); end
    endtask

    task automatic test_priority();
        reset_pulse();
        u_rd_req = 1'b1; u_rd_addr = 32'h2000_0003; u_load_type = 2'd2;
        d_rd_req = 1'b1; d_rd_addr = 32'h3000_0017;
        i_rd_req = 1'b1; i_rd_addr = 32'h4000_002C;
        @(negedge clk);
        n_tests++; if (m_rd_addr !== 32'h2000_0003 || m_rd_len !== 8'd0) begin n_fail++; $display("FAIL prio_first_u got %h/%0d want 20000003/0", m_rd_addr, m_rd_len); end
        u_rd_req = 1'b0;
        serve(1, 32'h77);
        n_tests++; if (u_ret_valid !== 1'b1 || d_rd_rdy !== 1'b0 || u_ret_data !== 32'h77) begin n_fail++; $display("FAIL prio_u_ret got %b/%b/%h want 1/0/77", u_ret_valid, d_rd_rdy, u_ret_data); end
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (m_rd_addr !== 32'h3000_0010) begin n_fail++; $display("FAIL prio_second_d got %h want 30000010", m_rd_addr); end
        d_rd_req = 1'b0;
        serve(4, 32'h1);
        n_tests++; if (d_ret_valid !== 1'b1) begin n_fail++; $display("FAIL prio_d_ret got %b want 1", d_ret_valid); end
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (m_rd_addr !== 32'h4000_0020) begin n_fail++; $display("FAIL prio_third_i got %h want 40000020", m_rd_addr); end
        i_rd_req = 1'b0;
        serve(4, 32'h2);
        n_tests++; if (i_ret_valid !== 1'b1) begin n_fail++; $display("FAIL prio_i_ret got %b want 1", i_ret_valid); end
        @(negedge clk);
    endtask

    // u and i held together: fixed priority grants u twice, rotation hands
    // the second grant to i.
    task automatic test_pair();
        reset_pulse();
        u_rd_req = 1'b1; u_rd_addr = 32'h2000_0004; u_load_type = 2'd2;
        i_rd_req = 1'b1; i_rd_addr = 32'h4000_0044;
        @(negedge clk);
        n_tests++; if (m_rd_addr !== 32'h2000_0004) begin n_fail++; $display("FAIL pair_first got %h want 20000004", m_rd_addr); end
        serve(1, 32'h5);
        @(negedge clk);
        @(negedge clk);
        u_rd_req = 1'b0; i_rd_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        n_tests++; if (m_rd_addr !== 32'h4000_0040) begin n_fail++; $display("FAIL pair_second got %h want 40000040", m_rd_addr); end
        serve(4, 32'h6);
`else
        n_tests++; if (m_rd_addr !== 32'h2000_0004) begin n_fail++; $display("FAIL pair_second got %h want 20000004", m_rd_addr); end
        serve(1, 32'h6);
`endif
        @(negedge clk);
    endtask

    task automatic test_uncached_half();
        u_rd_req = 1'b1; u_rd_addr = 32'hBFAF_8002; u_load_type = 2'd1;
        @(negedge clk);
        u_rd_req = 1'b0;
        n_tests++; if (m_rd_addr !== 32'hBFAF_8002 || m_rd_len !== 8'd0 || m_rd_size !== 3'd1) begin n_fail++; $display("FAIL uncached_req got %h/%0d/%0d want bfaf8002/0/1", m_rd_addr, m_rd_len, m_rd_size); end
        serve(1, 32'hCAFE_1234);
        n_tests++; if (u_ret_valid !== 1'b1 || u_ret_data !== 32'hCAFE_1234) begin n_fail++; $display("FAIL uncached_ret got %b/%h want 1/cafe1234", u_ret_valid, u_ret_data); end
        n_tests++; if (i_ret_valid !== 1'b0 || d_ret_valid !== 1'b0) begin n_fail++; $display("FAIL uncached_others got %b%b want 00", d_ret_valid, i_ret_valid); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        d_rd_req = 1'b1; d_rd_addr = 32'h8000_1234;
        @(negedge clk);
        d_rd_req = 1'b0;
        i_rd_req = 1'b1; i_rd_addr = 32'h0000_0400;
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (m_rd_req !== 1'b1 || m_rd_addr !== 32'h8000_1230 || m_rd_len !== 8'd3) begin n_fail++; $display("FAIL stall_c%0d got %b/%h/%0d want 1/80001230/3", c, m_rd_req, m_rd_addr, m_rd_len); end
            n_tests++; if (i_rd_rdy !== 1'b0 || d_ret_valid !== 1'b0 || i_ret_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wait_c%0d got %b/%b/%b want 0/0/0", c, i_rd_rdy, d_ret_valid, i_ret_valid); end
            @(negedge clk);
        end
        i_rd_req = 1'b0;
        serve(4, 32'h0101_0101);
        exp_line = {32'h0404_0404, 32'h0303_0303, 32'h0202_0202, 32'h0101_0101};
        n_tests++; if (d_ret_valid !== 1'b1 || d_ret_data !== exp_line) begin n_fail++; $display("FAIL stall_ret got %b/%h want 1/%h", d_ret_valid, d_ret_data, exp_line); end
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (m_rd_req !== 1'b0) begin n_fail++; $display("FAIL dropped_req got %b want 0", m_rd_req); end
    endtask

    task automatic test_reset_midburst();
        d_rd_req = 1'b1; d_rd_addr = 32'h0000_0040;
        @(negedge clk);
        d_rd_req = 1'b0;
        m_rd_rdy = 1'b1;
        @(negedge clk);
        m_rd_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_ret_valid = 1'b1; m_ret_data = 32'hEE00 + 32'(k);
            @(negedge clk);
        end
        m_ret_valid = 1'b0;
        resetn = 1'b0;
        #1;
        n_tests++; if (d_rd_rdy !== 1'b0 || m_rd_req !== 1'b0 || m_rd_addr !== 32'h0 || m_rd_len !== 8'd0) begin n_fail++; $display("FAIL midrst_ctrl got %b/%b/%h/%0d want 0/0/0/0", d_rd_rdy, m_rd_req, m_rd_addr, m_rd_len); end
        n_tests++; if (d_ret_data !== '0 || i_ret_data !== '0 || u_ret_data !== 32'h0) begin n_fail++; $display("FAIL midrst_data got %h/%h/%h want 0", d_ret_data, i_ret_data, u_ret_data); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_tests++; if (i_rd_rdy !== 1'b1 || d_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_release got %b%b want 11", d_rd_rdy, i_rd_rdy); end
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h1FC0_0024;
        @(negedge clk);
        i_rd_req = 1'b0;
        n_tests++; if (m_rd_addr !== 32'h1FC0_0020) begin n_fail++; $display("FAIL midrst_new_addr got %h want 1fc00020", m_rd_addr); end
        serve(4, 32'h10);
        exp_line = {32'h40, 32'h30, 32'h20, 32'h10};
        n_tests++; if (i_ret_valid !== 1'b1 || i_ret_data !== exp_line) begin n_fail++; $display("FAIL midrst_new_ret got %b/%h want 1/%h", i_ret_valid, i_ret_data, exp_line); end
        @(negedge clk);
    endtask

    task automatic test_early_last();
        i_rd_req = 1'b1; i_rd_addr = 32'h0000_0108;
        @(negedge clk);
        i_rd_req = 1'b0;
        serve(2, 32'hA0);
        exp_line = {32'h0, 32'h0, 32'h140, 32'hA0};
        n_tests++; if (i_ret_valid !== 1'b1 || i_ret_data !== exp_line) begin n_fail++; $display("FAIL early_last got %b/%h want 1/%h", i_ret_valid, i_ret_data, exp_line); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        d_rd_req = 1'b1; d_rd_addr = 32'h0000_0200;
        @(negedge clk);
        d_rd_req = 1'b0;
        serve(6, 32'h5);
        exp_line = {32'h14, 32'hF, 32'hA, 32'h5};
        n_tests++; if (d_ret_valid !== 1'b1 || d_ret_data !== exp_line) begin n_fail++; $display("FAIL overflow got %b/%h want 1/%h", d_ret_valid, d_ret_data, exp_line); end
        @(negedge clk);
    endtask

    task automatic test_idle_beat();
        m_ret_valid = 1'b1; m_ret_last = 1'b1; m_ret_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++; if (d_ret_valid !== 1'b0 || i_ret_valid !== 1'b0 || u_ret_valid !== 1'b0 || d_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_beat_c%0d got %b%b%b/%b want 000/1", c, u_ret_valid, d_ret_valid, i_ret_valid, d_rd_rdy); end
        end
        m_ret_valid = 1'b0; m_ret_last = 1'b0;
        exp_line = {32'h14, 32'hF, 32'hA, 32'h5};
        n_tests++; if (d_ret_data !== exp_line || m_rd_req !== 1'b0) begin n_fail++; $display("FAIL idle_beat_hold got %h/%b want %h/0", d_ret_data, m_rd_req, exp_line); end
    endtask

    initial begin
        test_reset();
        test_icache_refill();
        test_priority();
        test_pair();
        test_uncached_half();
        test_backpressure();
        test_reset_midburst();
        test_early_last();
        test_overflow();
        test_idle_beat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter: LINE_WORD, default 4, words per cache line (power of two, 2..16).
REQ-002 Parameter: LINE_W, default LINE_WORD*32, line width in bits.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 i_rd_req  in  1  ICache line-refill request.
REQ-006 i_rd_addr  in  32  ICache line address, physical.
REQ-007 i_rd_rdy  out  1  arbiter can accept an ICache request.
REQ-008 i_ret_valid  out  1  ICache line returned, one-cycle pulse.
REQ-009 i_ret_data  out  LINE_W  ICache line data.
REQ-010 d_rd_req / d_rd_addr / d_rd_rdy / d_ret_valid / d_ret_data  same directions and widths as the i_* ports  DCache line refill.
REQ-011 u_rd_req  in  1  uncached read request.
REQ-012 u_rd_addr  in  32  uncached read address.
REQ-013 u_load_type  in  LoadType  uncached access size.
REQ-014 u_rd_rdy  out  1  arbiter can accept an uncached request.
REQ-015 u_ret_valid  out  1  uncached word returned, one-cycle pulse.
REQ-016 u_ret_data  out  32  uncached read data.
REQ-017 m_rd_req  out  1  downstream AXI read request (valid).
REQ-018 m_rd_addr  out  32  downstream read address.
REQ-019 m_rd_len  out  8  burst beats minus one.
REQ-020 m_rd_size  out  3  bytes per beat, log2.
REQ-021 m_rd_rdy  in  1  downstream accepts the request.
REQ-022 m_ret_valid  in  1  downstream read beat valid.
REQ-023 m_ret_last  in  1  last beat of the burst.
REQ-024 m_ret_data  in  32  read beat data.

Function
REQ-025 The FSM SHALL have four states: IDLE, REQ, RECV, RESP; only one downstream read is outstanding at any time.
REQ-026 IDLE: when any *_rd_req is high, the block SHALL grant exactly one requester, latch its address, type and ID, and go to REQ the next cycle.
REQ-027 Fixed priority: u > d > i.
REQ-028 *_rd_rdy SHALL be high only in IDLE; a request is accepted when req and rdy are both high.
REQ-029 REQ: m_rd_req SHALL be 1 with the latched address and stay stable until m_rd_rdy=1, then the FSM goes to RECV.
REQ-030 Line grant: m_rd_len=LINE_WORD-1, m_rd_size=2, m_rd_addr low log2(LINE_WORD*4) bits zeroed.
REQ-031 Uncached grant: m_rd_len=0; m_rd_size from u_load_type (byte=0, half=1, word=2); full address passed unchanged.
REQ-032 RECV: each m_ret_valid beat SHALL be written to the line buffer at word k; k starts at 0 and increments per beat.
REQ-033 On the beat with m_ret_last=1, the FSM SHALL go to RESP.
REQ-034 Beats after LINE_WORD SHALL be dropped.
REQ-035 If last arrives early, unfilled words SHALL read as 0.
REQ-036 RESP, one cycle: exactly one of i/d/u_ret_valid SHALL pulse for the granted ID; the FSM then returns to IDLE.
REQ-037 Minimum latency: request accepted at cycle 0 -> m_rd_req at cycle 1 -> ret_valid one cycle after the last beat.
REQ-038 i/d_ret_data and u_ret_data SHALL hold their last values until the next RESP.
REQ-039 u_ret_data SHALL be beat 0 unmodified; byte/half extraction is done by the requester.
REQ-040 m_ret_valid outside RECV SHALL be ignored.
REQ-041 Requests deasserted before grant SHALL be lost without side effects.
REQ-042 Requests raised during REQ/RECV/RESP SHALL wait with rdy=0.

Reset
REQ-043 resetn=0 SHALL force IDLE at any time, including mid-burst; beat counter=0, last-grant pointer=i.
REQ-044 All outputs SHALL be 0 during reset, including *_rd_rdy, m_rd_req and all data.
REQ-045 Beats of a burst aborted by reset are not tracked; the downstream is reset on the same resetn.
REQ-046 First cycle after reset release: *_rd_rdy=1.

Configuration
REQ-047 Macro ARB_ROUND_ROBIN_EN defined: the grant SHALL rotate; the requester granted last has lowest priority next (order u->d->i->u).
REQ-048 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-027, and the pointer logic SHALL NOT be synthesized.

Verification
REQ-049 i_rd_req, addr 0x1FC0_0014, beats 0x11,0x22,0x33,0x44 -> m_rd_addr=0x1FC0_0010, len=3, size=2; i_ret_data={0x44,0x33,0x22,0x11}; i_ret_valid one pulse; d/u_ret_valid stay 0.
REQ-050 u, d and i requests raised in the same cycle, fixed priority -> order u, d, i; with ARB_ROUND_ROBIN_EN, u then d then i, and after a second u+i pair i is granted before u.
REQ-051 Uncached half read 0xBFAF_8002 -> m_rd_len=0, m_rd_size=1, m_rd_addr=0xBFAF_8002; u_ret_data equals beat 0.
REQ-052 m_rd_rdy held 0 for 5 cycles -> m_rd_req and addr stable for all 5 cycles; no ret_valid.
REQ-053 resetn pulled low after the 2nd beat of a d refill -> outputs 0 immediately; after release, IDLE with rdy=1; a new i request completes correctly.
REQ-054 m_ret_last asserted on beat 2 of 4 -> RESP with words 2..3 = 0; m_ret_valid in IDLE -> no effect.
